// File: rtl/tl_a_arbiter.sv
// Purpose: round-robin arbiter merging N_REQ upstream TileLink A channels onto one downstream A channel,
//          tagging the source with the grant index and routing D responses back by that index.
// Latency: one cycle of arbitration (IDLE -> GRANT), then A is combinational pass-through of the granted requester.
//          There is one idle bubble between bursts. D routing is purely combinational.
// Backpressure: the grant is held for the whole burst and while m_a_ready is low. a_ready mirrors m_a_ready on the granted lane only.
//          m_d_ready mirrors d_ready of the addressed requester.
// Ports: clk/rst_n; upstream a_* (packed per requester), a_ready; downstream m_a_*;
//        downstream m_d_valid/m_d_ready/m_d_source; upstream d_valid/d_ready/d_source; busy.

`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tl_a_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = `TL_ADDR_BITS,
    parameter int DATA_W = `TL_DATA_BYTES * 8,
    parameter int SRC_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            a_valid,
    output logic [N_REQ-1:0]            a_ready,
    input  logic [3*N_REQ-1:0]          a_opcode,
    input  logic [3*N_REQ-1:0]          a_size,
    input  logic [SRC_W*N_REQ-1:0]      a_source,
    input  logic [ADDR_W*N_REQ-1:0]     a_address,
    input  logic [(DATA_W/8)*N_REQ-1:0] a_mask,
    input  logic [DATA_W*N_REQ-1:0]     a_data,
    output logic                        m_a_valid,
    input  logic                        m_a_ready,
    output logic [2:0]                  m_a_opcode,
    output logic [2:0]                  m_a_size,
    output logic [SRC_W+1:0]            m_a_source,
    output logic [ADDR_W-1:0]           m_a_address,
    output logic [DATA_W/8-1:0]         m_a_mask,
    output logic [DATA_W-1:0]           m_a_data,
    input  logic                        m_d_valid,
    output logic                        m_d_ready,
    input  logic [SRC_W+1:0]            m_d_source,
    output logic [N_REQ-1:0]            d_valid,
    input  logic [N_REQ-1:0]            d_ready,
    output logic [SRC_W-1:0]            d_source,
    output logic                        busy
);

    localparam int IDX_W  = 2;
    localparam int MASK_W = DATA_W / 8;
    localparam int BEAT_W = 4;   // largest burst is 2^(7-3) = 16 beats

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   grant, grant_nxt;
    logic [IDX_W-1:0]   rr_last, rr_nxt;
    logic [BEAT_W-1:0]  beats_left, beats_nxt;
    logic [BEAT_W-1:0]  first_left;
    logic [4:0]         burst_len;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               accept;
    logic [IDX_W-1:0]   d_idx;

    // Downstream A fields always come from the granted lane; m_a_valid gates their meaning.
    assign m_a_opcode  = a_opcode[int'(grant)*3 +: 3];
    assign m_a_size    = a_size[int'(grant)*3 +: 3];
    assign m_a_source  = {grant, a_source[int'(grant)*SRC_W +: SRC_W]};
    assign m_a_address = a_address[int'(grant)*ADDR_W +: ADDR_W];
    assign m_a_mask    = a_mask[int'(grant)*MASK_W +: MASK_W];
    assign m_a_data    = a_data[int'(grant)*DATA_W +: DATA_W];

    assign m_a_valid = (state == GRANT) && a_valid[grant];
    assign accept    = m_a_valid && m_a_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        a_ready = '0;
        if (state == GRANT) begin
            a_ready[grant] = m_a_ready;
        end
    end

    // Only Puts larger than one data beat (8 bytes) are multi-beat.
    always_comb begin
        burst_len = 5'd1;
        if ((m_a_opcode == 3'd0 || m_a_opcode == 3'd1) && m_a_size > 3'd3) begin
            burst_len = 5'd1 << (m_a_size - 3'd3);
        end
        first_left = BEAT_W'(burst_len - 5'd1);
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        pick  = rr_last;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(rr_last) + k) % N_REQ);
            if (!found && a_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // beats_left == 0 while in GRANT means the next accepted beat is the first of the burst.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_last;
        beats_nxt = beats_left;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    grant_nxt = pick;
                end
            end
            GRANT: begin
                if (accept) begin
                    if ((beats_left == '0 && first_left == '0) || beats_left == BEAT_W'(1)) begin
                        state_nxt = IDLE;
                        rr_nxt    = grant;
                        beats_nxt = '0;
                    end else if (beats_left == '0) begin
                        beats_nxt = first_left;
                    end else begin
                        beats_nxt = beats_left - BEAT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            rr_last    <= IDX_W'(N_REQ - 1);
            beats_left <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            rr_last    <= rr_nxt;
            beats_left <= beats_nxt;
        end
    end

    // D routing is independent of the A-side state and of reset.
    assign d_idx    = m_d_source[SRC_W+1:SRC_W];
    assign d_source = m_d_source[SRC_W-1:0];
    assign m_d_ready = d_ready[d_idx];

    always_comb begin
        d_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            d_valid[i] = m_d_valid && (d_idx == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Purpose: directed self-checking bench for tl_a_arbiter.
// Latency: inputs change on the falling edge and outputs are sampled 1ns later.
// Backpressure: m_a_ready and d_ready are driven directly by the scenarios.
module tb_tl_a_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   a_valid = '0;
    logic [3:0]   a_ready;
    logic [11:0]  a_opcode = '0;
    logic [11:0]  a_size = '0;
    logic [15:0]  a_source = '0;
    logic [127:0] a_address = '0;
    logic [31:0]  a_mask = '0;
    logic [255:0] a_data = '0;
    logic         m_a_valid;
    logic         m_a_ready = 1'b0;
    logic [2:0]   m_a_opcode;
    logic [2:0]   m_a_size;
    logic [5:0]   m_a_source;
    logic [31:0]  m_a_address;
    logic [7:0]   m_a_mask;
    logic [63:0]  m_a_data;
    logic         m_d_valid = 1'b0;
    logic         m_d_ready;
    logic [5:0]   m_d_source = '0;
    logic [3:0]   d_valid;
    logic [3:0]   d_ready = '0;
    logic [3:0]   d_source;
    logic         busy;

    int tests_run = 0;
    int tests_failed = 0;

    tl_a_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(64), .SRC_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode), .m_a_size(m_a_size),
        .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_source(m_d_source),
        .d_valid(d_valid), .d_ready(d_ready), .d_source(d_source), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [2:0] op, input logic [2:0] sz,
                           input logic [3:0] src, input logic [31:0] addr, input logic [63:0] data);
        a_opcode[i*3 +: 3]   = op;
        a_size[i*3 +: 3]     = sz;
        a_source[i*4 +: 4]   = src;
        a_address[i*32 +: 32] = addr;
        a_mask[i*8 +: 8]     = 8'hFF;
        a_data[i*64 +: 64]   = data;
    endtask

    // Leaves the bench on a falling edge with reset just released and the arbiter idle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_valid = '0;
        m_a_ready = 1'b0;
        m_d_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 4'b1111;
        m_a_ready = 1'b1;
        m_d_valid = 1'b1;
        m_d_source = {2'd1, 4'h5};
        d_ready = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (m_a_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_a_valid: got %b want 0", m_a_valid); end
        tests_run++;
        if (a_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_a_ready: got %b want 0000", a_ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (d_valid !== 4'b0010) begin tests_failed++; $display("FAIL reset_d_valid: got %b want 0010", d_valid); end
        tests_run++;
        if (m_d_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_m_d_ready: got %b want 1", m_d_ready); end
        tests_run++;
        if (d_source !== 4'h5) begin tests_failed++; $display("FAIL reset_d_source: got %h want 5", d_source); end
        m_d_valid = 1'b0;
        d_ready = '0;
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int g;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 3'd4, 3'd3, 4'(8 + i), 32'h1000 * (i + 1), 64'(i));
        a_valid = 4'b1111;
        m_a_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            tests_run++;
            if (m_a_valid !== ((c % 2) == 1)) begin
                tests_failed++; $display("FAIL rr_valid c%0d: got %b want %b", c, m_a_valid, (c % 2) == 1);
            end
            if ((c % 2) == 1) begin
                g = exp_order[c / 2];
                tests_run++;
                if (m_a_source !== {2'(g), 4'(8 + g)}) begin
                    tests_failed++; $display("FAIL rr_source c%0d: got %h want %h", c, m_a_source, {2'(g), 4'(8 + g)});
                end
                tests_run++;
                if (a_ready !== 4'(1 << g)) begin
                    tests_failed++; $display("FAIL rr_a_ready c%0d: got %b want %b", c, a_ready, 4'(1 << g));
                end
            end
        end
    endtask

    task automatic test_burst();
        do_reset();
        set_req(2, 3'd0, 3'd5, 4'h7, 32'h2000, 64'hD0);
        set_req(0, 3'd4, 3'd3, 4'h1, 32'h0100, 64'h0);
        a_valid = 4'b0100;
        m_a_ready = 1'b1;
        #1;
        tests_run++;
        if (m_a_valid !== 1'b0) begin tests_failed++; $display("FAIL burst_arb_cycle: got %b want 0", m_a_valid); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            a_data[2*64 +: 64] = 64'hD0 + 64'(b);
            a_valid = 4'b0101;
            #1;
            tests_run++;
            if (m_a_valid !== 1'b1 || a_ready !== 4'b0100) begin
                tests_failed++; $display("FAIL burst_beat%0d_hs: got valid=%b a_ready=%b want 1/0100", b, m_a_valid, a_ready);
            end
            tests_run++;
            if (m_a_source !== {2'd2, 4'h7}) begin
                tests_failed++; $display("FAIL burst_beat%0d_source: got %h want %h", b, m_a_source, {2'd2, 4'h7});
            end
            tests_run++;
            if (m_a_data !== 64'hD0 + 64'(b)) begin
                tests_failed++; $display("FAIL burst_beat%0d_data: got %h want %h", b, m_a_data, 64'hD0 + 64'(b));
            end
        end
        @(negedge clk);
        a_valid = 4'b0001;
        #1;
        tests_run++;
        if (m_a_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL burst_bubble: got valid=%b busy=%b want 0/0", m_a_valid, busy);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (m_a_valid !== 1'b1 || m_a_source !== {2'd0, 4'h1}) begin
            tests_failed++; $display("FAIL burst_next_grant: got valid=%b source=%h want 1/%h", m_a_valid, m_a_source, {2'd0, 4'h1});
        end
    endtask

    task automatic test_single_get();
        do_reset();
        set_req(1, 3'd4, 3'd6, 4'h3, 32'h3000, 64'h33);
        a_valid = 4'b0010;
        m_a_ready = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (m_a_valid !== 1'b1 || m_a_source !== {2'd1, 4'h3}) begin
            tests_failed++; $display("FAIL get_grant: got valid=%b source=%h want 1/%h", m_a_valid, m_a_source, {2'd1, 4'h3});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (m_a_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL get_single_beat: got valid=%b busy=%b want 0/0", m_a_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 3'd4, 3'd2, 4'(4 + i), 32'h4000 + 32'(i), 64'(i));
        a_valid = 4'b0010;
        m_a_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            a_valid = ((c % 2) == 1) ? 4'b1111 : 4'b0010;
            #1;
            tests_run++;
            if (m_a_valid !== 1'b1 || m_a_source !== {2'd1, 4'h5} || m_a_address !== 32'h4001) begin
                tests_failed++;
                $display("FAIL stall_hold c%0d: got valid=%b source=%h addr=%h want 1/%h/00004001", c, m_a_valid, m_a_source, m_a_address, {2'd1, 4'h5});
            end
            tests_run++;
            if (a_ready !== 4'b0000) begin tests_failed++; $display("FAIL stall_a_ready c%0d: got %b want 0000", c, a_ready); end
        end
        @(negedge clk);
        m_a_ready = 1'b1;
        a_valid = 4'b1111;
        #1;
        tests_run++;
        if (a_ready !== 4'b0010 || m_a_source !== {2'd1, 4'h5}) begin
            tests_failed++; $display("FAIL stall_release: got a_ready=%b source=%h want 0010/%h", a_ready, m_a_source, {2'd1, 4'h5});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (m_a_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_accepted: got %b want 0", m_a_valid); end
        @(negedge clk);
        #1;
        tests_run++;
        if (m_a_source !== {2'd2, 4'h6} || m_a_valid !== 1'b1) begin
            tests_failed++; $display("FAIL stall_next_rr: got valid=%b source=%h want 1/%h", m_a_valid, m_a_source, {2'd2, 4'h6});
        end
    endtask

    task automatic test_d_route();
        do_reset();
        set_req(0, 3'd4, 3'd3, 4'h2, 32'h5000, 64'h0);
        a_valid = 4'b0001;
        m_a_ready = 1'b0;
        @(negedge clk);
        m_d_valid = 1'b1;
        m_d_source = {2'd3, 4'hA};
        d_ready = 4'b1000;
        #1;
        tests_run++;
        if (d_valid !== 4'b1000 || d_source !== 4'hA) begin
            tests_failed++; $display("FAIL d_route3: got d_valid=%b d_source=%h want 1000/a", d_valid, d_source);
        end
        tests_run++;
        if (m_d_ready !== 1'b1 || m_a_valid !== 1'b1) begin
            tests_failed++; $display("FAIL d_ready3_with_a: got m_d_ready=%b m_a_valid=%b want 1/1", m_d_ready, m_a_valid);
        end
        d_ready = 4'b0111;
        #1;
        tests_run++;
        if (m_d_ready !== 1'b0) begin tests_failed++; $display("FAIL d_ready3_low: got %b want 0", m_d_ready); end
        m_d_source = {2'd0, 4'h3};
        d_ready = 4'b0001;
        #1;
        tests_run++;
        if (d_valid !== 4'b0001 || m_d_ready !== 1'b1 || d_source !== 4'h3) begin
            tests_failed++; $display("FAIL d_route0: got d_valid=%b m_d_ready=%b d_source=%h want 0001/1/3", d_valid, m_d_ready, d_source);
        end
        m_d_valid = 1'b0;
        #1;
        tests_run++;
        if (d_valid !== 4'b0000) begin tests_failed++; $display("FAIL d_idle: got %b want 0000", d_valid); end
        d_ready = '0;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        set_req(1, 3'd0, 3'd5, 4'h9, 32'h6000, 64'h66);
        a_valid = 4'b0010;
        m_a_ready = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (m_a_valid !== 1'b1 || m_a_source !== {2'd1, 4'h9}) begin
            tests_failed++; $display("FAIL mid_beat1: got valid=%b source=%h want 1/%h", m_a_valid, m_a_source, {2'd1, 4'h9});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (m_a_valid !== 1'b0 || a_ready !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL mid_async_clear: got valid=%b a_ready=%b busy=%b want 0/0000/0", m_a_valid, a_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 3'd4, 3'd3, 4'(i), 32'h7000 + 32'(i), 64'(i));
        a_valid = 4'b1111;
        #1;
        tests_run++;
        if (m_a_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_release_idle: got %b want 0", m_a_valid); end
        @(negedge clk);
        #1;
        tests_run++;
        if (m_a_valid !== 1'b1 || m_a_source !== {2'd0, 4'h0}) begin
            tests_failed++; $display("FAIL mid_first_grant: got valid=%b source=%h want 1/%h", m_a_valid, m_a_source, {2'd0, 4'h0});
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_single_get();
        test_backpressure();
        test_d_route();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tl_a_arbiter.md
TL_A_ARBITER -- requirements
Module: tl_a_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of upstream L1 requesters; the index width is 2.
REQ-002 Parameter ADDR_W, default `TL_ADDR_BITS, SHALL set the address width.
REQ-003 Parameter DATA_W, default `TL_DATA_BYTES*8 (64), SHALL set the data width.
REQ-004 Parameter SRC_W, default 4, SHALL set the upstream source-ID width.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- a_valid  in  N_REQ  per-requester A valid.
- a_ready  out  N_REQ  per-requester A ready.
- a_opcode  in  3*N_REQ  packed opcodes.
- a_size  in  3*N_REQ  packed log2 byte sizes.
- a_source  in  SRC_W*N_REQ  packed source IDs.
- a_address  in  ADDR_W*N_REQ  packed addresses.
- a_mask  in  (DATA_W/8)*N_REQ  packed byte masks.
- a_data  in  DATA_W*N_REQ  packed data.
- m_a_valid / m_a_ready  out / in  1  downstream A handshake.
- m_a_opcode, m_a_size, m_a_address, m_a_mask, m_a_data  out  as upstream  the granted requester's fields.
- m_a_source  out  SRC_W+2  {grant index, upstream source}.
- m_d_valid / m_d_ready  in / out  1  downstream D handshake.
- m_d_source  in  SRC_W+2  D source with routing index in bits [SRC_W+1:SRC_W].
- d_valid / d_ready  out / in  N_REQ  per-requester D handshake.
- d_source  out  SRC_W  m_d_source[SRC_W-1:0], broadcast to all requesters.
- busy  out  1  state != IDLE.

Function
REQ-007 The FSM SHALL have the states IDLE and GRANT, plus a registered 2-bit grant, a registered round-robin pointer rr_last, and a beat counter beats_left.
REQ-008 In IDLE with any a_valid set, the block SHALL select the first valid requester starting at rr_last+1 (mod N_REQ), register it as grant, and enter GRANT on the next edge; this gives one cycle of arbitration latency.
REQ-009 In IDLE, m_a_valid SHALL be 0 and all a_ready bits SHALL be 0.
REQ-010 In GRANT, the m_a_* outputs SHALL be driven from requester grant, m_a_valid SHALL equal a_valid[grant], and a_ready SHALL equal m_a_ready for bit grant only (0 for all other bits).
REQ-011 A beat SHALL count as accepted when m_a_valid && m_a_ready.
REQ-012 On the first accepted beat, beats_left SHALL load the total beat count minus 1, where the total is:
- For opcode 0 (PutFull) or 1 (PutPartial) with size > 3: 2^(size-3).
- Otherwise: 1.
REQ-013 Each later accepted beat SHALL decrement beats_left.
REQ-014 On acceptance of the final beat, the block SHALL return to IDLE and set rr_last to grant; the next grant is issued no earlier than the following cycle, so there is exactly one bubble between bursts.
REQ-015 The grant SHALL NOT change mid-burst or while m_a_valid is 1 and m_a_ready is 0, regardless of other requesters' a_valid.
REQ-016 Upstream a_valid falling in GRANT before the final beat is a protocol violation; the block SHALL hold the grant and wait, with no timeout.
REQ-017 D routing SHALL be purely combinational:
- d_valid[i] = m_d_valid && (m_d_source[SRC_W+1:SRC_W] == i).
- m_d_ready = d_ready[index].
REQ-018 D routing SHALL be independent of A-channel state, so D and A traffic may proceed in the same cycle.
REQ-019 The design SHALL reach no stuck state: when N_REQ requesters are continuously valid with single-beat requests, each requester SHALL be granted once per N_REQ grants.

Reset
REQ-020 While rst_n is 0, and asynchronously on its assertion, the block SHALL force:
- state = IDLE.
- grant = 0.
- rr_last = N_REQ-1, so requester 0 has first priority.
- beats_left = 0.
- m_a_valid, a_ready, and busy = 0.
REQ-021 Reset asserted mid-burst SHALL abandon the burst; after release the block SHALL re-arbitrate from the reset pointer.
REQ-022 D-path outputs SHALL follow their combinational inputs during reset.

Verification
REQ-023 Scenario 1: after reset, a_valid=4'b1111 with all single-beat Gets and m_a_ready=1.
- Required grant order: 0,1,2,3,0.
- m_a_valid SHALL be low on every other cycle.
REQ-024 Scenario 2: requester 2 issues PutFull with size=5 (4 beats) and requester 0 is valid throughout.
- Requester 2 SHALL complete 4 consecutive accepted beats before requester 0 is granted.
- m_a_source SHALL be {2'd2, src}.
REQ-025 Scenario 3: m_a_ready=0 for 5 cycles during a granted beat while other requesters toggle a_valid.
- m_a_* SHALL remain stable and the grant SHALL be unchanged.
- The beat SHALL be accepted when ready rises.
REQ-026 Scenario 4: m_d_valid=1 with m_d_source={2'd3, 4'hA}.
- d_valid SHALL be 4'b1000 and d_source SHALL be 4'hA.
- m_d_ready SHALL track d_ready[3] in the same cycle.
REQ-027 Scenario 5: rst_n pulsed low after beat 2 of a 4-beat PutFull from requester 1.
- Outputs SHALL clear immediately.
- With all requesters valid after release, the first grant SHALL be requester 0.
